// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - assembles a little-endian byte stream into 32-bit words and writes them to instruction memory
// Holds the core in reset until the requested number of words has been written.
module imem_boot_loader #(
  parameter int INS_ADDRESS = 9,
  parameter int INS_W       = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic [INS_ADDRESS-2:0] num_words,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [INS_ADDRESS-1:0] wa,
  output logic [INS_W-1:0]       wd,
  output logic                   we,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic [31:0]            checksum,
  output logic                   cpu_hold
);

  localparam int DEPTH = 2 ** (INS_ADDRESS - 2);
  localparam logic [INS_ADDRESS-3:0] CNT_ONE   = (INS_ADDRESS-2)'(1);
  localparam logic [INS_ADDRESS-2:0] COUNT_ONE = (INS_ADDRESS-1)'(1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t                 state;
  logic [INS_ADDRESS-2:0] count;
  logic [INS_ADDRESS-3:0] word_cnt;
  logic [1:0]             byte_idx;
  logic [31:0]            asm_word;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      count    <= '0;
      word_cnt <= '0;
      byte_idx <= '0;
      asm_word <= '0;
      in_ready <= 1'b0;
      wa       <= '0;
      wd       <= '0;
      we       <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      checksum <= '0;
      cpu_hold <= 1'b1;
    end else begin
      we <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            checksum <= '0;
            if (num_words == '0) begin
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b0;
              cpu_hold <= 1'b0;
            end else if (32'(num_words) > 32'(DEPTH)) begin
              // Oversized image: report and keep the core parked.
              state    <= DONE;
              done     <= 1'b1;
              err      <= 1'b1;
              cpu_hold <= 1'b1;
            end else begin
              state    <= LOAD;
              count    <= num_words;
              word_cnt <= '0;
              byte_idx <= '0;
              err      <= 1'b0;
              done     <= 1'b0;
              busy     <= 1'b1;
              in_ready <= 1'b1;
              cpu_hold <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (in_valid && in_ready) begin
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              wd       <= {in_data, asm_word[23:0]};
              wa       <= {word_cnt, 2'b00};
              we       <= 1'b1;
              in_ready <= 1'b0;
              state    <= WRITE;
            end else begin
              asm_word[8*byte_idx +: 8] <= in_data;
            end
          end
        end
        WRITE: begin
          checksum <= checksum + wd;
          if ({1'b0, word_cnt} == count - COUNT_ONE) begin
            state    <= DONE;
            done     <= 1'b1;
            busy     <= 1'b0;
            cpu_hold <= 1'b0;
          end else begin
            word_cnt <= word_cnt + CNT_ONE;
            in_ready <= 1'b1;
            state    <= LOAD;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - randomized self-checking bench for imem_boot_loader
// Expected writes and checksums come from a byte-array image model.
module tb_imem_boot_loader;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [7:0]  num_words;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [8:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] checksum;
  logic        cpu_hold;

  int checks = 0;
  int errors = 0;

  logic [7:0]  img [0:1023];
  logic [8:0]  w_addr [$];
  logic [31:0] w_data [$];
  int          rdy_viol = 0;

  imem_boot_loader #(.INS_ADDRESS(9), .INS_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .num_words(num_words),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .wa(wa), .wd(wd), .we(we), .busy(busy), .done(done), .err(err),
    .checksum(checksum), .cpu_hold(cpu_hold)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (we === 1'b1) begin
      w_addr.push_back(wa);
      w_data.push_back(wd);
      if (in_ready !== 1'b0) rdy_viol++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  function automatic logic [31:0] model_word(input int i);
    return {img[4*i+3], img[4*i+2], img[4*i+1], img[4*i]};
  endfunction

  function automatic logic [31:0] model_sum(input int n);
    logic [31:0] s = 0;
    for (int i = 0; i < n; i++) s += model_word(i);
    return s;
  endfunction

  task automatic clear_mon();
    w_addr.delete();
    w_data.delete();
    rdy_viol = 0;
  endtask

  task automatic fill_random(input int nbytes);
    for (int i = 0; i < nbytes; i++) img[i] = 8'($urandom);
  endtask

  task automatic pulse_start(input logic [7:0] n);
    @(negedge clk);
    start = 1'b1;
    num_words = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input int from, input int to, input bit gaps);
    int idx = from;
    int cyc = 0;
    while (idx < to && cyc < 4000) begin
      @(negedge clk);
      cyc++;
      in_valid = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data  = img[idx];
      if (in_valid && in_ready) idx++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_data  = 8'($urandom);
    checks++;
    if (idx !== to) begin
      errors++;
      $display("FAIL drive_timeout accepted %0d required %0d", idx, to);
    end
  endtask

  task automatic wait_done();
    for (int c = 0; c < 300 && done !== 1'b1; c++) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; num_words = '0; in_data = '0; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, we, busy, done, err, cpu_hold} !== 6'b000001) begin
      errors++; $display("FAIL reset_flags got %b required 000001", {in_ready, we, busy, done, err, cpu_hold});
    end
    checks++;
    if ({wa, wd, checksum} !== '0) begin
      errors++; $display("FAIL reset_data got wa=%h wd=%h cs=%h required 0", wa, wd, checksum);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({in_ready, we, busy, done, cpu_hold} !== 5'b00001) begin
      errors++; $display("FAIL idle_flags got %b required 00001", {in_ready, we, busy, done, cpu_hold});
    end
  endtask

  task automatic test_directed();
    logic [7:0] b [8] = '{8'h13, 8'h00, 8'h10, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    for (int i = 0; i < 8; i++) img[i] = b[i];
    clear_mon();
    pulse_start(8'd2);
    checks++;
    if ({busy, in_ready, cpu_hold, done} !== 4'b1110) begin
      errors++; $display("FAIL load_flags got %b required 1110", {busy, in_ready, cpu_hold, done});
    end
    drive(0, 8, 1'b0);
    checks++;
    if (we !== 1'b1 || wa !== 9'h004 || wd !== 32'h00100093) begin
      errors++; $display("FAIL last_write_latency got we=%b wa=%h wd=%h required we=1 wa=004 wd=00100093", we, wa, wd);
    end
    @(negedge clk);
    checks++;
    if ({done, we, busy, cpu_hold} !== 4'b1000 || checksum !== 32'h002000A6) begin
      errors++; $display("FAIL directed_done got flags=%b cs=%h required 1000 cs=002000a6", {done, we, busy, cpu_hold}, checksum);
    end
    checks++;
    if (w_addr.size() != 2 || w_addr[0] !== 9'h000 || w_data[0] !== 32'h00100013) begin
      errors++; $display("FAIL directed_first_write got n=%0d required wa=000 wd=00100013", w_addr.size());
    end
  endtask

  task automatic test_gaps();
    for (int it = 0; it < 4; it++) begin
      int n = (it == 0) ? 2 : $urandom_range(1, 8);
      int bad = 0;
      if (it != 0) fill_random(4 * n);
      clear_mon();
      pulse_start(8'(n));
      drive(0, 4 * n, 1'b1);
      wait_done();
      for (int i = 0; i < n && i < w_addr.size(); i++)
        if (w_addr[i] !== 9'(4 * i) || w_data[i] !== model_word(i)) bad++;
      checks++;
      if (w_addr.size() != n || bad != 0) begin
        errors++; $display("FAIL gaps_writes it=%0d got n=%0d bad=%0d required n=%0d bad=0", it, w_addr.size(), bad, n);
      end
      checks++;
      if (done !== 1'b1 || checksum !== model_sum(n) || rdy_viol != 0) begin
        errors++; $display("FAIL gaps_done it=%0d got done=%b cs=%h rv=%0d required done=1 cs=%h rv=0", it, done, checksum, rdy_viol, model_sum(n));
      end
    end
  endtask

  task automatic test_full();
    int bad = 0;
    fill_random(512);
    clear_mon();
    pulse_start(8'd128);
    drive(0, 512, 1'b0);
    wait_done();
    for (int i = 0; i < 128 && i < w_addr.size(); i++)
      if (w_addr[i] !== 9'(4 * i) || w_data[i] !== model_word(i)) bad++;
    checks++;
    if (w_addr.size() != 128 || bad != 0) begin
      errors++; $display("FAIL full_writes got n=%0d bad=%0d required n=128 bad=0", w_addr.size(), bad);
    end
    checks++;
    if (w_addr.size() == 0 || w_addr[w_addr.size()-1] !== 9'h1FC) begin
      errors++; $display("FAIL full_last_addr got n=%0d required last wa=1fc", w_addr.size());
    end
    checks++;
    if ({done, err, cpu_hold} !== 3'b100 || checksum !== model_sum(128)) begin
      errors++; $display("FAIL full_done got %b cs=%h required 100 cs=%h", {done, err, cpu_hold}, checksum, model_sum(128));
    end
  endtask

  task automatic test_errors();
    clear_mon();
    pulse_start(8'(129 + $urandom_range(0, 126)));
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 8'($urandom);
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (w_addr.size() != 0 || {done, err, cpu_hold, busy, in_ready} !== 5'b11100) begin
      errors++; $display("FAIL oversize got writes=%0d flags=%b required 0 11100", w_addr.size(), {done, err, cpu_hold, busy, in_ready});
    end
    pulse_start(8'd0);
    repeat (2) @(negedge clk);
    checks++;
    if (w_addr.size() != 0 || {done, err, cpu_hold, busy} !== 4'b1000 || checksum !== 32'h0) begin
      errors++; $display("FAIL zero_words got writes=%0d flags=%b cs=%h required 0 1000 0", w_addr.size(), {done, err, cpu_hold, busy}, checksum);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    fill_random(12);
    clear_mon();
    pulse_start(8'd3);
    drive(0, 6, 1'b0);
    in_valid = 1'b1;
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({in_ready, we, busy, done, err, cpu_hold} !== 6'b000001 || checksum !== 32'h0 || wa !== 9'h0 || wd !== 32'h0) begin
      errors++; $display("FAIL async_reset got flags=%b cs=%h wa=%h wd=%h required 000001 0 0 0", {in_ready, we, busy, done, err, cpu_hold}, checksum, wa, wd);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b0;
    fill_random(8);
    clear_mon();
    pulse_start(8'd2);
    drive(0, 8, 1'b1);
    wait_done();
    for (int i = 0; i < 2 && i < w_addr.size(); i++)
      if (w_addr[i] !== 9'(4 * i) || w_data[i] !== model_word(i)) bad++;
    checks++;
    if (w_addr.size() != 2 || bad != 0 || checksum !== model_sum(2)) begin
      errors++; $display("FAIL reload_after_reset got n=%0d bad=%0d cs=%h required 2 0 %h", w_addr.size(), bad, checksum, model_sum(2));
    end
  endtask

  task automatic test_start_mid();
    int bad = 0;
    fill_random(12);
    clear_mon();
    pulse_start(8'd3);
    drive(0, 5, 1'b1);
    pulse_start(8'd1);
    drive(5, 12, 1'b1);
    wait_done();
    for (int i = 0; i < 3 && i < w_addr.size(); i++)
      if (w_addr[i] !== 9'(4 * i) || w_data[i] !== model_word(i)) bad++;
    checks++;
    if (w_addr.size() != 3 || bad != 0) begin
      errors++; $display("FAIL start_mid_writes got n=%0d bad=%0d required 3 0", w_addr.size(), bad);
    end
    checks++;
    if (done !== 1'b1 || checksum !== model_sum(3)) begin
      errors++; $display("FAIL start_mid_done got done=%b cs=%h required 1 %h", done, checksum, model_sum(3));
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_gaps();
    test_full();
    test_errors();
    test_reset_mid();
    test_start_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
